// File: rtl/wb_port_arbiter.sv
// Register file write-port arbiter: the pipeline write-back stage has priority,
// long-latency results wait in a small FIFO and drain in idle write slots.
// A starvation counter forces a one-cycle stall so buffered results always drain.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_we,
    input  logic [ADDR_W-1:0]             wb_waddr,
    input  logic [DATA_W-1:0]             wb_wdata,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [ADDR_W-1:0]             lu_waddr,
    input  logic [DATA_W-1:0]             lu_wdata,
    output logic                          stall_req,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    input  logic [ADDR_W-1:0]             q1_addr,
    output logic                          q1_hit,
    input  logic [ADDR_W-1:0]             q2_addr,
    output logic                          q2_hit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;

    entry_t                head;
    logic                  not_empty;
    logic                  wb_valid;
    logic                  pop;
    logic                  push;
    logic                  store;
    logic [FIFO_DEPTH-1:0] ent_valid;

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign wb_valid  = wb_we && (wb_waddr != '0);
    assign lu_ready  = rst && (count < CNT_W'(FIFO_DEPTH));
    assign stall_req = rst && not_empty && (starve_cnt == STV_W'(STARVE_MAX));
    assign push      = lu_valid && lu_ready;
    assign store     = push && (lu_waddr != '0);
    assign fifo_cnt  = count;

    // Write-port arbitration: forced drain, then pipeline, then idle-slot drain.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        pop      = 1'b0;
        if (rst) begin
            if (stall_req) begin
                rf_we    = 1'b1;
                rf_waddr = head.waddr;
                rf_wdata = head.wdata;
                pop      = 1'b1;
            end else if (wb_valid) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
                // The pipeline write is younger, so a matching head is stale.
                pop      = not_empty && (head.waddr == wb_waddr);
            end else if (not_empty) begin
                rf_we    = 1'b1;
                rf_waddr = head.waddr;
                rf_wdata = head.wdata;
                pop      = 1'b1;
            end
        end
    end

    // Pointer, occupancy and starvation state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(store) - CNT_W'(pop);
            if (!not_empty || pop) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful where ent_valid is set.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= '{waddr: lu_waddr, wdata: lu_wdata};
        end
    end

    // An entry is live when its distance from rd_ptr is below count.
    always_comb begin
        ent_valid = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
        end
    end

    // Scoreboard hits against every live entry, including one popping now.
    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (mem[i].waddr == q1_addr)) begin
                q1_hit = 1'b1;
            end
            if (ent_valid[i] && (mem[i].waddr == q2_addr)) begin
                q2_hit = 1'b1;
            end
        end
        q1_hit = q1_hit && rst && (q1_addr != '0);
        q2_hit = q2_hit && rst && (q2_addr != '0);
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline write-back stage and one long-latency unit (divider or multi-cycle MAC result path).
- Pipeline writes have priority and zero added latency. Long-latency results are buffered in a small FIFO and drained in idle write slots.
- A starvation counter forces a one-cycle pipeline stall so that buffered results always drain.
- Per-read-port scoreboard hits tell the decode stage that a pending buffered write targets its source register.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (address 0 is the hard-wired zero register).
- FIFO_DEPTH, 2, pending long-latency results (power of two, >=2).
- STARVE_MAX, 4, consecutive cycles the FIFO head may lose arbitration before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_we  in  1  pipeline write-back valid.
- wb_waddr  in  ADDR_W  pipeline destination register.
- wb_wdata  in  DATA_W  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_waddr  in  ADDR_W  long-latency destination register.
- lu_wdata  in  DATA_W  long-latency result data.
- stall_req  out  1  to pipeline control; hold the WB stage for one cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- q1_addr  in  ADDR_W  read port 1 source register.
- q1_hit  out  1  a pending FIFO entry targets q1_addr.
- q2_addr  in  ADDR_W  read port 2 source register.
- q2_hit  out  1  a pending FIFO entry targets q2_addr.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
Reset:
- rst low clears wr_ptr, rd_ptr, count and starve_cnt.
- While rst is low: rf_we=0, rf_waddr=0, rf_wdata=0, lu_ready=0, stall_req=0, q1_hit=0, q2_hit=0, fifo_cnt=0.
- A reset asserted mid-operation discards all buffered results without writing them.

Enqueue:
- lu_ready = (count < FIFO_DEPTH), derived from registered state only and never from lu_valid.
- Handshake occurs on a rising edge with lu_valid && lu_ready; the entry is written at wr_ptr.
- A result with lu_waddr==0 is accepted (handshake completes) but not stored.
- A stored entry is earliest visible on rf_* in the cycle after the handshake (minimum latency 1).

Arbitration (combinational rf_* outputs, evaluated each cycle; wb_valid = wb_we && wb_waddr!=0):
1. stall_req=1 and count>0: grant the FIFO head, pop it. The pipeline write is not performed; the pipeline re-presents it next cycle.
2. Otherwise, if wb_valid: grant the pipeline; rf_* = wb_*.
   - If count>0 and the head address equals wb_waddr, pop and discard the head. The pipeline write is younger and the head is stale.
3. Otherwise, if count>0: grant the head, pop it.
4. Otherwise rf_we=0.
- wb_we with wb_waddr==0 never produces rf_we.

Count:
- Push and pop in the same cycle leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Pop never occurs when count==0.

Starvation:
- starve_cnt increments each cycle in which count>0 and the head is not popped.
- starve_cnt clears on any pop or when count==0.
- stall_req = (starve_cnt == STARVE_MAX) && count>0, decoded from registers.
- After the forced pop, starve_cnt=0, so stall_req lasts exactly one cycle per forced drain.

Scoreboard:
- qN_hit=1 iff some valid entry has waddr==qN_addr and qN_addr!=0.
- An entry popped this cycle still reports a hit this cycle.
- A result being enqueued this cycle does not report a hit until the next cycle.

Test Plan:
1. Reset, then idle: all outputs 0 during reset; after release lu_ready=1, fifo_cnt=0, rf_we=0.
2. Enqueue r5=0xDEADBEEF while wb_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, fifo_cnt returns to 0. During the pending cycle q1_addr=5 gives q1_hit=1.
3. Enqueue r7=0x11 and r8=0x22 back to back with wb_we held high to r3 -> fifo_cnt=2, lu_ready=0. After 4 losing cycles stall_req=1 for one cycle and rf writes r7=0x11. Four cycles later r8=0x22 is written the same way. The wb write to r3 is absent on each stall cycle.
4. FIFO head r9=0x55 while wb writes r9=0x99 -> rf writes r9=0x99, head discarded, fifo_cnt decrements, r9 never receives 0x55.
5. lu result to r0 and wb_we to r0 -> handshake completes, fifo_cnt stays 0, rf_we stays 0.
6. Drop rst with fifo_cnt=2 -> fifo_cnt=0 immediately. After release no rf_we pulse occurs for the discarded entries.
